// File: rtl/dct_sequencer.sv
// dct_sequencer: address/control sequencer for an N x N 2-D transform
// datapath, N = 2**LOG2_N. For every outer (result) index it streams all
// N*N inner (sample) indices to the sample RAM, drives the MAC enables,
// waits out the MAC pipeline and writes the result back.
// Optional feature macro: DCT_SEQ_HOLD_EN enables the Hold stall input
// during RUN; without it Hold is ignored.
module dct_sequencer #(
    parameter int unsigned LOG2_N      = 3,
    parameter int unsigned MAC_LATENCY = 2
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic                  Mode,
    input  logic                  Hold,
    output logic                  Ready,
    output logic                  Done,
    output logic [LOG2_N-1:0]     u,
    output logic [LOG2_N-1:0]     v,
    output logic [LOG2_N-1:0]     x,
    output logic [LOG2_N-1:0]     y,
    output logic                  Read_Enable,
    output logic [2*LOG2_N-1:0]   Address,
    output logic                  Active_MAC,
    output logic                  Clear_MAC,
    output logic                  Write_Enable,
    output logic [2*LOG2_N-1:0]   Write_Address
);

    localparam int unsigned AW    = 2 * LOG2_N;
    localparam int unsigned CNT_W = (MAC_LATENCY < 1) ? 1 : $clog2(MAC_LATENCY + 1);
    localparam logic [AW-1:0]    IDX_LAST = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAC_LATENCY);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t            state_q,         state_d;
    logic [AW-1:0]     inner_q,         inner_d;
    logic [AW-1:0]     outer_q,         outer_d;
    logic [CNT_W-1:0]  cnt_q,           cnt_d;
    logic              mode_q,          mode_d;
    logic              read_enable_q,   read_enable_d;
    logic              write_enable_q,  write_enable_d;
    logic              done_q,          done_d;
    logic              ready_q,         ready_d;
    logic              active_mac_q,    active_mac_d;
    logic              clear_mac_q,     clear_mac_d;
    logic [AW-1:0]     address_q,       address_d;
    logic [AW-1:0]     write_address_q, write_address_d;
    logic [LOG2_N-1:0] u_q, u_d, v_q, v_d, x_q, x_d, y_q, y_d;

    logic hold_c;

`ifdef DCT_SEQ_HOLD_EN
    // Stall request honoured only while streaming samples
    assign hold_c = Hold;
`else
    // Stall feature compiled out; the input is tied off
    assign hold_c = Hold & 1'b0;
`endif

    // State and counter registers, plus registered copies of every output
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q         <= S_IDLE;
            inner_q         <= '0;
            outer_q         <= '0;
            cnt_q           <= '0;
            mode_q          <= 1'b0;
            read_enable_q   <= 1'b0;
            write_enable_q  <= 1'b0;
            done_q          <= 1'b0;
            ready_q         <= 1'b1;
            active_mac_q    <= 1'b0;
            clear_mac_q     <= 1'b0;
            address_q       <= '0;
            write_address_q <= '0;
            u_q             <= '0;
            v_q             <= '0;
            x_q             <= '0;
            y_q             <= '0;
        end else begin
            state_q         <= state_d;
            inner_q         <= inner_d;
            outer_q         <= outer_d;
            cnt_q           <= cnt_d;
            mode_q          <= mode_d;
            read_enable_q   <= read_enable_d;
            write_enable_q  <= write_enable_d;
            done_q          <= done_d;
            ready_q         <= ready_d;
            active_mac_q    <= active_mac_d;
            clear_mac_q     <= clear_mac_d;
            address_q       <= address_d;
            write_address_q <= write_address_d;
            u_q             <= u_d;
            v_q             <= v_d;
            x_q             <= x_d;
            y_q             <= y_d;
        end
    end

    // Next-state logic: walk inner terms, drain MAC pipe, write result
    always_comb begin
        state_d        = state_q;
        inner_d        = inner_q;
        outer_d        = outer_q;
        cnt_d          = cnt_q;
        mode_d         = mode_q;
        read_enable_d  = 1'b0;
        write_enable_d = 1'b0;
        done_d         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d       = S_RUN;
                    inner_d       = '0;
                    outer_d       = '0;
                    mode_d        = Mode;
                    read_enable_d = 1'b1;
                end
            end
            S_RUN: begin
                // A term presented with Read_Enable high is consumed; a
                // stalled term stays on Address until Hold releases
                if (read_enable_q) begin
                    if (inner_q == IDX_LAST) begin
                        state_d = S_DRAIN;
                        inner_d = '0;
                        cnt_d   = '0;
                    end else begin
                        inner_d       = inner_q + AW'(1);
                        read_enable_d = !hold_c;
                    end
                end else begin
                    read_enable_d = !hold_c;
                end
            end
            S_DRAIN: begin
                if (cnt_q == CNT_LAST) begin
                    state_d        = S_WRITE;
                    write_enable_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WRITE: begin
                if (outer_q == IDX_LAST) begin
                    state_d = S_IDLE;
                    outer_d = '0;
                    done_d  = 1'b1;
                end else begin
                    state_d       = S_RUN;
                    outer_d       = outer_q + AW'(1);
                    inner_d       = '0;
                    read_enable_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from next-state values so outputs line up with state
    always_comb begin
        ready_d         = (state_d == S_IDLE);
        address_d       = inner_d;
        write_address_d = outer_d;
        active_mac_d    = read_enable_q;
        clear_mac_d     = read_enable_q && (inner_q == '0);
        if (mode_d) begin
            x_d = outer_d[AW-1:LOG2_N];
            y_d = outer_d[LOG2_N-1:0];
            u_d = inner_d[AW-1:LOG2_N];
            v_d = inner_d[LOG2_N-1:0];
        end else begin
            u_d = outer_d[AW-1:LOG2_N];
            v_d = outer_d[LOG2_N-1:0];
            x_d = inner_d[AW-1:LOG2_N];
            y_d = inner_d[LOG2_N-1:0];
        end
    end

    assign Ready         = ready_q;
    assign Done          = done_q;
    assign u             = u_q;
    assign v             = v_q;
    assign x             = x_q;
    assign y             = y_q;
    assign Read_Enable   = read_enable_q;
    assign Address       = address_q;
    assign Active_MAC    = active_mac_q;
    assign Clear_MAC     = clear_mac_q;
    assign Write_Enable  = write_enable_q;
    assign Write_Address = write_address_q;

endmodule

// File: tb/tb_dct_sequencer.sv
// tb_dct_sequencer: directed bench for dct_sequencer. Instance a is the
// 8x8 forward configuration (LOG2_N=3, MAC_LATENCY=2), instance b the 4x4
// configuration (LOG2_N=2, MAC_LATENCY=0) used in inverse mode.
// Hold scenario is built only when DCT_SEQ_HOLD_EN is defined.
module tb_dct_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // instance a: N=8, MAC_LATENCY=2
    logic       rst_a, start_a, mode_a, hold_a;
    logic       ready_a, done_a, re_a, am_a, cm_a, we_a;
    logic [2:0] u_a, v_a, x_a, y_a;
    logic [5:0] addr_a, wa_a;

    // instance b: N=4, MAC_LATENCY=0
    logic       rst_b, start_b, mode_b, hold_b;
    logic       ready_b, done_b, re_b, am_b, cm_b, we_b;
    logic [1:0] u_b, v_b, x_b, y_b;
    logic [3:0] addr_b, wa_b;

    dct_sequencer #(.LOG2_N(3), .MAC_LATENCY(2)) dut_a (
        .Clock(clk), .Reset(rst_a), .Start(start_a), .Mode(mode_a), .Hold(hold_a),
        .Ready(ready_a), .Done(done_a), .u(u_a), .v(v_a), .x(x_a), .y(y_a),
        .Read_Enable(re_a), .Address(addr_a), .Active_MAC(am_a), .Clear_MAC(cm_a),
        .Write_Enable(we_a), .Write_Address(wa_a)
    );

    dct_sequencer #(.LOG2_N(2), .MAC_LATENCY(0)) dut_b (
        .Clock(clk), .Reset(rst_b), .Start(start_b), .Mode(mode_b), .Hold(hold_b),
        .Ready(ready_b), .Done(done_b), .u(u_b), .v(v_b), .x(x_b), .y(y_b),
        .Read_Enable(re_b), .Address(addr_b), .Active_MAC(am_b), .Clear_MAC(cm_b),
        .Write_Enable(we_b), .Write_Address(wa_b)
    );

    // Reset both instances for two edges; outputs must be at reset values
    task automatic test_reset();
        logic [29:0] obs_a;
        logic [21:0] obs_b;
        rst_a = 1'b1; rst_b = 1'b1;
        start_a = 1'b0; mode_a = 1'b0; hold_a = 1'b0;
        start_b = 1'b0; mode_b = 1'b0; hold_b = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        obs_a = {ready_a, done_a, re_a, am_a, cm_a, we_a, addr_a, wa_a, u_a, v_a, x_a, y_a};
        obs_b = {ready_b, done_b, re_b, am_b, cm_b, we_b, addr_b, wa_b, u_b, v_b, x_b, y_b};
        total++;
        if (obs_a !== {1'b1, 29'd0}) begin
            bad++;
            $display("FAIL reset_a got=%h exp=%h", obs_a, {1'b1, 29'd0});
        end
        total++;
        if (obs_b !== {1'b1, 21'd0}) begin
            bad++;
            $display("FAIL reset_b got=%h exp=%h", obs_b, {1'b1, 21'd0});
        end
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);
        obs_a = {ready_a, done_a, re_a, am_a, cm_a, we_a, addr_a, wa_a, u_a, v_a, x_a, y_a};
        total++;
        if (obs_a !== {1'b1, 29'd0}) begin
            bad++;
            $display("FAIL idle_after_reset_a got=%h exp=%h", obs_a, {1'b1, 29'd0});
        end
    endtask

    // Full forward block on instance a with per-cycle expected outputs.
    // glitch: pulse Start and raise Mode at cycle 20. hold: Hold during
    // cycles 9..11 so cycles 10..12 present address 10 without a read.
    task automatic run_block_a(input string name, input bit glitch, input bit hold);
        int h, e, p, o, wes;
        bit held;
        logic       ere, ewe, edone, erdy, pre;
        logic [5:0] ea, eo, pa;
        logic [23:0] obs, exp_v;
        h = hold ? 3 : 0;
        wes = 0; pre = 1'b0; pa = '0;
        @(negedge clk);
        start_a = 1'b1; mode_a = 1'b0;
        for (int c = 0; c <= 4353 + h; c++) begin
            @(negedge clk);
            held = hold && (c >= 10) && (c < 13);
            e = held ? 10 : ((hold && c >= 13) ? c - 3 : c);
            if (e < 4352) begin
                p = e % 68; o = e / 68;
                ere = (p < 64) && !held;
                ea  = (p < 64) ? 6'(p) : 6'd0;
                ewe = (p == 67);
                edone = 1'b0; erdy = 1'b0;
                eo = 6'(o);
            end else begin
                ere = 1'b0; ea = '0; ewe = 1'b0;
                edone = (e == 4352); erdy = 1'b1; eo = '0;
            end
            exp_v = {ere, ea, pre, pre && (pa == 6'd0), ewe, edone, erdy,
                     eo[5:3], eo[2:0], ea[5:3], ea[2:0]};
            obs   = {re_a, addr_a, am_a, cm_a, we_a, done_a, ready_a, u_a, v_a, x_a, y_a};
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL %s cyc=%0d got=%h exp=%h", name, c, obs, exp_v);
            end
            if (ewe) begin
                total++;
                if (wa_a !== eo) begin
                    bad++;
                    $display("FAIL %s_waddr cyc=%0d got=%0d exp=%0d", name, c, wa_a, eo);
                end
            end
            if (we_a === 1'b1) wes++;
            pre = ere; pa = ea;
            start_a = glitch && (c == 20);
            if (glitch && c == 20) mode_a = 1'b1;
            hold_a = hold && (c >= 9) && (c <= 11);
        end
        total++;
        if (wes !== 64) begin
            bad++;
            $display("FAIL %s_we_count got=%0d exp=64", name, wes);
        end
        start_a = 1'b0; mode_a = 1'b0; hold_a = 1'b0;
    endtask

    task automatic test_forward();
        run_block_a("forward", 1'b0, 1'b0);
    endtask

    task automatic test_start_mid_run();
        run_block_a("mid_start", 1'b1, 1'b0);
    endtask

    // Reset at cycle 100: reset values next cycle, then quiet, then full block
    task automatic test_reset_mid();
        logic [29:0] obs;
        logic [2:0]  q;
        @(negedge clk);
        start_a = 1'b1;
        for (int c = 0; c <= 100; c++) begin
            @(negedge clk);
            start_a = 1'b0;
            if (c == 100) rst_a = 1'b1;
        end
        @(negedge clk);
        rst_a = 1'b0;
        obs = {ready_a, done_a, re_a, am_a, cm_a, we_a, addr_a, wa_a, u_a, v_a, x_a, y_a};
        total++;
        if (obs !== {1'b1, 29'd0}) begin
            bad++;
            $display("FAIL reset_mid got=%h exp=%h", obs, {1'b1, 29'd0});
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            q = {we_a, done_a, ready_a};
            total++;
            if (q !== 3'b001) begin
                bad++;
                $display("FAIL reset_mid_quiet cyc=%0d got=%b exp=001", c, q);
            end
        end
        run_block_a("after_reset", 1'b0, 1'b0);
    endtask

    // Inverse block on instance b, then Start on the Done cycle
    task automatic test_inverse_back_to_back();
        int e, p, o;
        logic       ere, ewe, edone, erdy, pre;
        logic [3:0] ea, eo, pa;
        logic [17:0] obs, exp_v;
        logic [2:0]  q;
        pre = 1'b0; pa = '0;
        @(negedge clk);
        start_b = 1'b1; mode_b = 1'b1;
        for (int c = 0; c <= 288; c++) begin
            @(negedge clk);
            start_b = 1'b0; mode_b = 1'b0;
            e = c;
            if (e < 288) begin
                p = e % 18; o = e / 18;
                ere = (p < 16);
                ea  = (p < 16) ? 4'(p) : 4'd0;
                ewe = (p == 17);
                edone = 1'b0; erdy = 1'b0;
                eo = 4'(o);
            end else begin
                ere = 1'b0; ea = '0; ewe = 1'b0;
                edone = 1'b1; erdy = 1'b1; eo = '0;
            end
            // inverse: x,y follow the outer index, u,v the inner index
            exp_v = {ere, ea, pre, pre && (pa == 4'd0), ewe, edone, erdy,
                     ea[3:2], ea[1:0], eo[3:2], eo[1:0]};
            obs   = {re_b, addr_b, am_b, cm_b, we_b, done_b, ready_b, u_b, v_b, x_b, y_b};
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL inverse cyc=%0d got=%h exp=%h", c, obs, exp_v);
            end
            if (ewe) begin
                total++;
                if (wa_b !== eo) begin
                    bad++;
                    $display("FAIL inverse_waddr cyc=%0d got=%0d exp=%0d", c, wa_b, eo);
                end
            end
            pre = ere; pa = ea;
            if (c == 288) start_b = 1'b1;
        end
        @(negedge clk);
        start_b = 1'b0;
        q = {re_b, ready_b, done_b};
        total++;
        if (q !== 3'b100 || addr_b !== 4'd0) begin
            bad++;
            $display("FAIL back_to_back got=%b addr=%0d exp=100 addr=0", q, addr_b);
        end
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
    endtask

`ifdef DCT_SEQ_HOLD_EN
    task automatic test_hold();
        run_block_a("hold", 1'b0, 1'b1);
    endtask
`endif

    initial begin
        test_reset();
        test_forward();
        test_start_mid_run();
        test_reset_mid();
        test_inverse_back_to_back();
`ifdef DCT_SEQ_HOLD_EN
        test_hold();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dct_sequencer.md
# dct_sequencer

Parametrised address/control sequencer for the 2-D transform datapath. It generalises the fixed 8×8 forward controller to any power-of-two block side N = 2^LOG2_N, with a configurable MAC pipeline depth and a runtime forward/inverse mode. It walks every output coefficient, streams all N² input samples for each one, and steers the sample memory read port, the MAC enables and the result write-back. It sits between the sample RAM and the MAC/coefficient-ROM datapath.

## Interface
- LOG2_N, 3, log2 of block side; N = 2^LOG2_N, index width LOG2_N, address width 2·LOG2_N
- MAC_LATENCY, 2, cycles from the last Active_MAC to a valid accumulator result (≥0)
- Clock  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- Start  in  1  begin a block; sampled only in IDLE
- Mode  in  1  0 = forward (outer {u,v}, inner {x,y}), 1 = inverse (outer {x,y}, inner {u,v}); latched when Start is accepted
- Hold  in  1  stall request (active only with DCT_SEQ_HOLD_EN)
- Ready  out  1  high while IDLE
- Done  out  1  one-cycle pulse on block completion
- u, v, x, y  out  LOG2_N each  current frequency and spatial indices
- Read_Enable  out  1  sample RAM read strobe
- Address  out  2·LOG2_N  read address = inner index
- Active_MAC  out  1  MAC accumulate enable (Read_Enable delayed 1 cycle)
- Clear_MAC  out  1  with Active_MAC on first inner term: load instead of accumulate
- Write_Enable  out  1  result write strobe
- Write_Address  out  2·LOG2_N  result address = outer index

## Operation
- States: IDLE, RUN, DRAIN, WRITE.
- IDLE: Ready=1. Start=1 → RUN; outer index O=0, inner index I=0, Mode latched.
- RUN: Read_Enable=1, Address=I; I increments each cycle; after I=N²−1 → DRAIN, I wraps to 0.
- DRAIN: lasts MAC_LATENCY+1 cycles (cycle counter); then → WRITE.
- WRITE: one cycle, Write_Enable=1, Write_Address=O. If O=N²−1 → IDLE with Done=1 for that first IDLE cycle; else O+1, → RUN.
- Index mapping: forward {u,v}=O, {x,y}=I; inverse {x,y}=O, {u,v}=I. Upper half of each index is u or x.
- Active_MAC = registered Read_Enable; Clear_MAC = registered (Read_Enable && I==0).
- Start while not IDLE ignored; Mode change mid-block ignored.
- Counters wrap modulo N²; no overflow state.

## Timing
- Reset values: Ready=1; Done, Read_Enable, Active_MAC, Clear_MAC, Write_Enable=0; u,v,x,y, Address, Write_Address=0; state IDLE.
- Reset mid-operation: next edge forces reset values; no Done, no pending Write_Enable.
- Start sampled at edge k in IDLE → cycle 0 (first RUN cycle) follows edge k; Ready falls in cycle 0.
- Per outer index, period P = N² + MAC_LATENCY + 2 cycles: RUN 0..N²−1, DRAIN N²..N²+MAC_LATENCY, WRITE N²+MAC_LATENCY+1.
- Memory read latency is 1 cycle; Active_MAC for Address a is the cycle after a is presented.
- Done (and Ready=1) in cycle N²·P. N=8, MAC_LATENCY=2: P=68, Done at cycle 4352.
- Start on the Done cycle accepted (IDLE) → next block starts immediately.

## Configuration
- DCT_SEQ_HOLD_EN defined: Hold=1 during RUN freezes I and O, forces Read_Enable=0 (Active_MAC/Clear_MAC drop one cycle later); the held term is reissued when Hold falls. Hold has no effect in IDLE, DRAIN, WRITE. Total latency grows by the number of held RUN cycles.
- Not defined: Hold ignored; timing strictly as above.

## Test plan
- Reset: assert Reset 2 cycles → all outputs at reset values, Ready=1.
- Forward, LOG2_N=3, MAC_LATENCY=2: Start one cycle → Address 0..63 in cycles 0..63, Clear_MAC at cycle 1, Write_Enable at cycle 67 with Write_Address 0, Done at cycle 4352, exactly 64 Write_Enable pulses.
- Inverse, LOG2_N=2, MAC_LATENCY=0: Start with Mode=1 → P=18, x,y track outer, u,v track inner, Done at cycle 288.
- Start pulsed mid-RUN and Mode toggled → no restart, sequence and Done cycle unchanged.
- Reset at cycle 100 of a block → reset values next cycle, no Write_Enable or Done; fresh Start runs a full block.
- DCT_SEQ_HOLD_EN, Hold high 3 cycles at RUN cycle 10 → Address 10 held, Read_Enable=0 for 3 cycles, Done delayed by exactly 3 cycles.
